// File: rtl/blink_pkg.sv
// Shared types and helpers for the blink generator / blink meter pair.
package blink_pkg;

  typedef enum logic [1:0] {
    S_SYNC,
    S_HIGH,
    S_LOW,
    S_TIMEOUT
  } meter_state_t;

  // Divide first so large clock rates times long intervals stay inside 32 bits.
  function automatic int ms_to_ticks(input int f_clk, input int ms);
    return (f_clk / 1000) * ms;
  endfunction

  localparam int DEFAULT_F_CLK_HZ = 25_000_000;

endpackage

// File: rtl/sync_edge.sv
// Synchronizer chain plus previous-level flop; reports the synchronized level and its edges.
module sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  localparam int FILL_MAX = SYNC_STAGES + 1;
  localparam int FW       = $clog2(FILL_MAX + 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev;
  logic [FW-1:0]          fill;
  logic                   primed;

  // Edges stay masked until the chain and prev have refilled after reset, so a wave
  // already high at reset release is not mistaken for a fresh rise.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
      prev   <= 1'b0;
      fill   <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], din};
      prev   <= sync_q[SYNC_STAGES-1];
      if (fill != FW'(FILL_MAX)) fill <= fill + 1'b1;
    end
  end

  assign primed = (fill == FW'(FILL_MAX));
  assign level  = sync_q[SYNC_STAGES-1];
  assign rise   = primed &  level & ~prev;
  assign fall   = primed & ~level &  prev;

endmodule

// File: rtl/blink_meter.sv
// Measures high time, low time and period of an asynchronous square wave in whole ms,
// and flags loss of signal when no edge arrives for TIMEOUT_MS.
module blink_meter
  import blink_pkg::*;
#(
  parameter int F_CLK_HZ    = DEFAULT_F_CLK_HZ,
  parameter int MS_W        = 16,
  parameter int TIMEOUT_MS  = 5000,
  parameter int SYNC_STAGES = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            wave_in,
  output logic [MS_W-1:0] on_ms,
  output logic [MS_W-1:0] off_ms,
  output logic [MS_W:0]   period_ms,
  output logic            meas_valid,
  output logic            locked,
  output logic            timeout,
  output logic [2:0]      meas_cnt
);

  localparam int              TICKS_PER_MS = ms_to_ticks(F_CLK_HZ, 1);
  localparam int              PW           = $clog2(TICKS_PER_MS);
  localparam logic [MS_W-1:0] SEG_MAX      = '1;
  localparam logic [MS_W-1:0] TIMEOUT_VAL  = MS_W'(TIMEOUT_MS);

  if (TICKS_PER_MS < 2) begin : g_chk_ticks
    $error("blink_meter: F_CLK_HZ must give at least 2 ticks per ms");
  end
  if (TIMEOUT_MS >= (2 ** MS_W) - 1) begin : g_chk_timeout
    $error("blink_meter: TIMEOUT_MS must be below 2**MS_W-1");
  end
  if (SYNC_STAGES < 2) begin : g_chk_sync
    $error("blink_meter: SYNC_STAGES must be at least 2");
  end

  logic            wave_s, rise, fall, any_edge;
  logic [PW-1:0]   presc, presc_now;
  logic            ms_tick;
  logic [MS_W-1:0] seg_ms, high_lat;
  meter_state_t    state, state_next;
  logic            load_high, load_meas, set_timeout, clr_timeout;

  sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk   (clk),
    .rst   (rst),
    .din   (wave_in),
    .level (wave_s),
    .rise  (rise),
    .fall  (fall)
  );

  assign any_edge = rise | fall;

  // The edge cycle itself counts as prescaler 0, so N clocks between edges read as
  // floor(N / TICKS_PER_MS) ms and an edge never coincides with a tick.
  assign presc_now = any_edge ? '0 : presc;
  assign ms_tick   = (presc_now == PW'(TICKS_PER_MS - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      presc  <= '0;
      seg_ms <= '0;
    end else begin
      presc <= ms_tick ? '0 : presc_now + 1'b1;
      if (any_edge)
        seg_ms <= '0;
      else if (ms_tick && seg_ms != SEG_MAX)
        seg_ms <= seg_ms + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= S_SYNC;
    else     state <= state_next;
  end

  always_comb begin
    state_next  = state;
    load_high   = 1'b0;
    load_meas   = 1'b0;
    set_timeout = 1'b0;
    clr_timeout = 1'b0;
    unique case (state)
      S_SYNC:    if (rise) state_next = S_HIGH;
      S_HIGH:    if (fall) begin
                   load_high  = 1'b1;
                   state_next = S_LOW;
                 end
      S_LOW:     if (any_edge && wave_s) begin
                   load_meas  = 1'b1;
                   state_next = S_HIGH;
                 end
      S_TIMEOUT: if (rise) begin
                   clr_timeout = 1'b1;
                   state_next  = S_HIGH;
                 end
      default:   state_next = S_SYNC;
    endcase
    // An edge arriving in the same cycle keeps the measurement alive.
    if (state != S_TIMEOUT && !any_edge && seg_ms == TIMEOUT_VAL) begin
      state_next  = S_TIMEOUT;
      set_timeout = 1'b1;
      load_high   = 1'b0;
      load_meas   = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      high_lat   <= '0;
      on_ms      <= '0;
      off_ms     <= '0;
      period_ms  <= '0;
      meas_valid <= 1'b0;
      locked     <= 1'b0;
      timeout    <= 1'b0;
      meas_cnt   <= '0;
    end else begin
      meas_valid <= load_meas;
      if (load_high) high_lat <= seg_ms;
      if (load_meas) begin
        on_ms     <= high_lat;
        off_ms    <= seg_ms;
        period_ms <= {1'b0, high_lat} + {1'b0, seg_ms};
        locked    <= 1'b1;
        meas_cnt  <= meas_cnt + 1'b1;
      end
      if (set_timeout) begin
        timeout <= 1'b1;
        locked  <= 1'b0;
      end else if (clr_timeout) begin
        timeout <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_blink_meter.sv
// Directed bench for blink_meter at 4 clocks per ms and an 8 ms loss-of-signal limit.
module tb_blink_meter;

  localparam int F_CLK_HZ    = 4000;
  localparam int MS_W        = 16;
  localparam int TIMEOUT_MS  = 8;
  localparam int SYNC_STAGES = 2;

  logic            clk     = 1'b0;
  logic            rst     = 1'b1;
  logic            wave_in = 1'b0;
  logic [MS_W-1:0] on_ms, off_ms;
  logic [MS_W:0]   period_ms;
  logic            meas_valid, locked, timeout;
  logic [2:0]      meas_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  blink_meter #(
    .F_CLK_HZ    (F_CLK_HZ),
    .MS_W        (MS_W),
    .TIMEOUT_MS  (TIMEOUT_MS),
    .SYNC_STAGES (SYNC_STAGES)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .wave_in    (wave_in),
    .on_ms      (on_ms),
    .off_ms     (off_ms),
    .period_ms  (period_ms),
    .meas_valid (meas_valid),
    .locked     (locked),
    .timeout    (timeout),
    .meas_cnt   (meas_cnt)
  );

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic lvl, input int n);
    wave_in = lvl;
    tick(n);
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_on"},     on_ms,      0);
    checkOutput({tag, "_off"},    off_ms,     0);
    checkOutput({tag, "_period"}, period_ms,  0);
    checkOutput({tag, "_valid"},  meas_valid, 0);
    checkOutput({tag, "_locked"}, locked,     0);
    checkOutput({tag, "_timeout"},timeout,    0);
    checkOutput({tag, "_cnt"},    meas_cnt,   0);
  endtask

  // One rise followed by h high clocks and l low clocks; the strobe for the
  // previous high/low pair is expected 3 clocks after the rise is driven.
  task automatic runPeriod(input int h, input int l, input bit strobe,
                           input int exp_on, input int exp_off, input int exp_cnt);
    applyStimulus(1'b1, 3);
    checkOutput("strobe_at_rise", meas_valid, strobe);
    if (strobe) begin
      checkOutput("on_ms",     on_ms,     exp_on);
      checkOutput("off_ms",    off_ms,    exp_off);
      checkOutput("period_ms", period_ms, exp_on + exp_off);
      checkOutput("meas_cnt",  meas_cnt,  exp_cnt);
      checkOutput("locked",    locked,    1);
    end
    tick(1);
    checkOutput("strobe_one_clk", meas_valid, 0);
    tick(h - 4);
    applyStimulus(1'b0, l);
  endtask

  initial begin
    // reset state
    tick(3);
    checkAllZero("reset");
    rst = 1'b0;
    applyStimulus(1'b0, 8);

    // 3 ms high / 2 ms low; first rise only starts, then 8 strobes wrap the counter
    runPeriod(12, 8, 1'b0, 0, 0, 0);
    for (int i = 1; i <= 8; i++) runPeriod(12, 8, 1'b1, 3, 2, i % 8);

    // 2.75 ms high / 1 ms low floors to 2 / 1
    runPeriod(11, 4, 1'b1, 3, 2, 1);
    runPeriod(11, 4, 1'b1, 2, 1, 2);
    runPeriod(12, 8, 1'b1, 2, 1, 3);

    // loss of signal after lock
    applyStimulus(1'b1, 3);
    checkOutput("pre_to_strobe", meas_valid, 1);
    checkOutput("pre_to_cnt",    meas_cnt,   4);
    applyStimulus(1'b1, 9);
    applyStimulus(1'b0, 34);
    checkOutput("to_not_yet",     timeout, 0);
    checkOutput("locked_not_yet", locked,  1);
    tick(1);
    checkOutput("to_set",      timeout,   1);
    checkOutput("to_unlocked", locked,    0);
    checkOutput("to_on_hold",  on_ms,     3);
    checkOutput("to_off_hold", off_ms,    2);
    checkOutput("to_per_hold", period_ms, 5);
    checkOutput("to_cnt_hold", meas_cnt,  4);
    applyStimulus(1'b0, 5);
    applyStimulus(1'b1, 2);
    checkOutput("to_still_set", timeout, 1);
    tick(1);
    checkOutput("to_cleared",     timeout,    0);
    checkOutput("to_no_strobe",   meas_valid, 0);
    checkOutput("to_still_unlck", locked,     0);
    tick(9);
    applyStimulus(1'b0, 8);
    runPeriod(12, 8, 1'b1, 3, 2, 5);

    // reset mid-high with the wave still high at release
    applyStimulus(1'b1, 3);
    checkOutput("pre_rst_cnt", meas_cnt, 6);
    tick(3);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    checkAllZero("midrst");
    applyStimulus(1'b1, 4);
    applyStimulus(1'b0, 8);
    checkOutput("midrst_no_strobe", meas_valid, 0);
    runPeriod(12, 8, 1'b0, 0, 0, 0);
    runPeriod(12, 8, 1'b1, 3, 2, 1);
    checkOutput("end_timeout", timeout, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
